// File: rtl/metric_batch_scheduler_pkg.sv
// rtl/metric_batch_scheduler_pkg.sv - shared widths, state encoding and magnitude helper
package metric_batch_scheduler_pkg;

    localparam int ENTRY_W  = 10;
    localparam int CPLX_W   = 20;
    localparam int N_ENTRY  = 4;
    localparam int METRIC_W = 10;
    localparam int SUM_W    = 13;
    localparam int CAND_W   = N_ENTRY * CPLX_W;
    localparam int N_COMP   = 2 * N_ENTRY;

    localparam logic [METRIC_W-1:0] METRIC_INIT = 10'h3FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // -512 wraps to 10'h200, which read as unsigned is the correct magnitude
    function automatic logic [ENTRY_W-1:0] abs_mag(input logic [ENTRY_W-1:0] x);
        return x[ENTRY_W-1] ? (~x + ENTRY_W'(1)) : x;
    endfunction

endpackage

// File: rtl/metric_batch_scheduler_abs_sum4_pipe.sv
// rtl/metric_batch_scheduler_abs_sum4_pipe.sv - 2-stage L1 magnitude and sum pipe with valid/idx tags
module abs_sum4_pipe
    import metric_batch_scheduler_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                en,
    input  logic                in_valid,
    input  logic [IDX_W-1:0]    in_idx,
    input  logic [CAND_W-1:0]   in_cand,
    output logic                s1_valid,
    output logic                out_valid,
    output logic [IDX_W-1:0]    out_idx,
    output logic [METRIC_W-1:0] out_metric
);

    logic [ENTRY_W-1:0] mag [N_COMP];
    logic [IDX_W-1:0]   s1_idx;
    logic [SUM_W-1:0]   sum_c;
    logic               unused_sum_bits;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N_COMP; i++) mag[i] <= '0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else if (en) begin
            for (int i = 0; i < N_COMP; i++) mag[i] <= abs_mag(in_cand[i*ENTRY_W +: ENTRY_W]);
            s1_valid <= in_valid;
            s1_idx   <= in_idx;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N_COMP; i++) sum_c = sum_c + SUM_W'(mag[i]);
    end

    // Bit 12 is dropped on purpose: a sum of exactly 4096 folds to metric 0
    assign unused_sum_bits = ^{sum_c[SUM_W-1], sum_c[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_metric <= '0;
        end else if (en) begin
            out_valid  <= s1_valid;
            out_idx    <= s1_idx;
            out_metric <= sum_c[METRIC_W+1:2];
        end
    end

endmodule

// File: rtl/metric_batch_scheduler.sv
// rtl/metric_batch_scheduler.sv - batch FSM, accept counter and minimum-metric tracking
module metric_batch_scheduler
    import metric_batch_scheduler_pkg::*;
#(
    parameter int N_MAX = 64,
    parameter int IDX_W = $clog2(N_MAX)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [IDX_W:0]      i_num_cand,
    input  logic                i_cand_valid,
    output logic                o_cand_ready,
    input  logic [CAND_W-1:0]   i_cand,
    output logic                o_busy,
    output logic                o_done,
    output logic [IDX_W-1:0]    o_best_idx,
    output logic [METRIC_W-1:0] o_best_metric
);

    state_t              state, state_nx;
    logic [IDX_W:0]      num_cand_q;
    logic [IDX_W:0]      accepted;
    logic                accept;
    logic                pipe_en;
    logic                s1_valid;
    logic                s2_valid;
    logic [IDX_W-1:0]    s2_idx;
    logic [METRIC_W-1:0] s2_metric;

    assign o_cand_ready = (state == ST_RUN) && (accepted < num_cand_q);
    assign accept       = i_cand_valid & o_cand_ready;
    assign pipe_en      = (state == ST_RUN) || (state == ST_DRAIN);
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // The stage-2 slot retires into the compare on the same edge we leave DRAIN,
    // so only stage 1 needs to be empty for the pipe to be clear afterwards.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (i_start) state_nx = (i_num_cand == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (accepted == num_cand_q) state_nx = ST_DRAIN;
            ST_DRAIN: if (!s1_valid) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            num_cand_q    <= '0;
            accepted      <= '0;
            o_best_metric <= METRIC_INIT;
            o_best_idx    <= '0;
        end else if (state == ST_IDLE && i_start) begin
            num_cand_q    <= i_num_cand;
            accepted      <= '0;
            o_best_metric <= METRIC_INIT;
            o_best_idx    <= '0;
        end else begin
            if (accept) accepted <= accepted + {{IDX_W{1'b0}}, 1'b1};
            // Strict less-than keeps the earlier index on ties
            if (s2_valid && (s2_metric < o_best_metric)) begin
                o_best_metric <= s2_metric;
                o_best_idx    <= s2_idx;
            end
        end
    end

    abs_sum4_pipe #(
        .IDX_W(IDX_W)
    ) u_pipe (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .en         (pipe_en),
        .in_valid   (accept),
        .in_idx     (accepted[IDX_W-1:0]),
        .in_cand    (i_cand),
        .s1_valid   (s1_valid),
        .out_valid  (s2_valid),
        .out_idx    (s2_idx),
        .out_metric (s2_metric)
    );

endmodule

// File: tb/tb_metric_batch_scheduler.sv
// tb/tb_metric_batch_scheduler.sv - directed self-checking bench for metric_batch_scheduler
module tb_metric_batch_scheduler;

    localparam int N_MAX = 64;
    localparam int IDX_W = 6;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_start;
    logic [IDX_W:0]   i_num_cand;
    logic             i_cand_valid;
    logic             o_cand_ready;
    logic [79:0]      i_cand;
    logic             o_busy;
    logic             o_done;
    logic [IDX_W-1:0] o_best_idx;
    logic [9:0]       o_best_metric;

    int vectors     = 0;
    int miscompares = 0;

    metric_batch_scheduler #(
        .N_MAX(N_MAX),
        .IDX_W(IDX_W)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_num_cand    (i_num_cand),
        .i_cand_valid  (i_cand_valid),
        .o_cand_ready  (o_cand_ready),
        .i_cand        (i_cand),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_best_idx    (o_best_idx),
        .o_best_metric (o_best_metric)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [79:0] mk(input logic [9:0] r1, input logic [9:0] i1,
                                       input logic [9:0] r2, input logic [9:0] i2,
                                       input logic [9:0] r3, input logic [9:0] i3,
                                       input logic [9:0] r4, input logic [9:0] i4);
        return {i4, r4, i3, r3, i2, r2, i1, r1};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_batch(input int n);
        i_start    = 1'b1;
        i_num_cand = (IDX_W+1)'(n);
        tick();
        i_start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (o_done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(o_done), 1);
    endtask

    logic [79:0] t5 [5];
    int          acc;
    int          ptr;
    int          cyc;
    logic        rdy;
    logic        saw_done;

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_num_cand = '0; i_cand_valid = 1'b0; i_cand = '0;
        tick(); tick(); tick();
        i_reset = 1'b0;
        check("rst_busy",   32'(o_busy), 0);
        check("rst_done",   32'(o_done), 0);
        check("rst_ready",  32'(o_cand_ready), 0);
        check("rst_idx",    32'(o_best_idx), 0);
        check("rst_metric", 32'(o_best_metric), 32'h3FF);

        // T1: |5| + |-3| = 8 -> metric 2, exact latency
        start_batch(1);
        check("t1_ready", 32'(o_cand_ready), 1);
        check("t1_busy",  32'(o_busy), 1);
        i_cand_valid = 1'b1;
        i_cand = mk(10'd5, 10'h3FD, 0, 0, 0, 0, 0, 0);
        tick();
        i_cand_valid = 1'b0;
        check("t1_ready_after", 32'(o_cand_ready), 0);
        check("t1_done_k0", 32'(o_done), 0);
        tick();
        check("t1_done_k1", 32'(o_done), 0);
        tick();
        check("t1_done_k2", 32'(o_done), 1);
        check("t1_metric",  32'(o_best_metric), 2);
        check("t1_idx",     32'(o_best_idx), 0);
        tick();
        check("t1_done_off", 32'(o_done), 0);
        check("t1_idle",     32'(o_busy), 0);
        check("t1_hold",     32'(o_best_metric), 2);

        // T2: metrics 40, 12, 12 back-to-back; tie keeps index 1
        start_batch(3);
        i_cand_valid = 1'b1;
        i_cand = mk(0, 0, 10'd60, 0, 0, 0, 0, 10'h39C);
        tick();
        i_cand = mk(10'h3EC, 0, 0, 10'd28, 0, 0, 0, 0);
        tick();
        i_cand = mk(0, 0, 0, 0, 10'd48, 0, 0, 0);
        tick();
        i_cand_valid = 1'b0;
        check("t2_ready_full", 32'(o_cand_ready), 0);
        check("t2_done_k2", 32'(o_done), 0);
        tick();
        check("t2_done_k3", 32'(o_done), 0);
        tick();
        check("t2_done_k4", 32'(o_done), 1);
        check("t2_metric",  32'(o_best_metric), 12);
        check("t2_idx",     32'(o_best_idx), 1);
        tick();

        // T3: all eight components -512 -> sum 4096 -> metric 0
        start_batch(1);
        i_cand_valid = 1'b1;
        i_cand = mk(10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 10'h200);
        tick();
        i_cand_valid = 1'b0;
        wait_done("t3", 10);
        check("t3_metric", 32'(o_best_metric), 0);
        check("t3_idx",    32'(o_best_idx), 0);
        tick();

        // T4: empty batch with a candidate offered anyway
        i_cand_valid = 1'b1;
        start_batch(0);
        check("t4_done",   32'(o_done), 1);
        check("t4_ready",  32'(o_cand_ready), 0);
        check("t4_metric", 32'(o_best_metric), 32'h3FF);
        check("t4_idx",    32'(o_best_idx), 0);
        tick();
        check("t4_done_off", 32'(o_done), 0);
        check("t4_ready2",   32'(o_cand_ready), 0);
        check("t4_idle",     32'(o_busy), 0);
        i_cand_valid = 1'b0;

        // T5: metrics 30, 25, 9, 17 then an extra 3 that must never be taken
        t5[0] = mk(10'd120, 0, 0, 0, 0, 0, 0, 0);
        t5[1] = mk(0, 10'h39C, 0, 0, 0, 0, 0, 0);
        t5[2] = mk(0, 0, 10'd20, 0, 0, 10'h3F0, 0, 0);
        t5[3] = mk(0, 0, 0, 0, 0, 0, 10'd68, 0);
        t5[4] = mk(10'd12, 0, 0, 0, 0, 0, 0, 0);
        start_batch(4);
        acc = 0; ptr = 0; cyc = 0;
        while (o_done !== 1'b1 && cyc < 200) begin
            i_cand_valid = ($urandom_range(0, 1) == 1);
            i_cand       = t5[ptr];
            i_start      = (cyc == 3);
            i_num_cand   = (cyc == 3) ? 7'd1 : 7'd0;
            rdy          = o_cand_ready;
            tick();
            if (i_cand_valid && rdy) begin
                acc++;
                ptr = (acc < 4) ? acc : 4;
            end
            cyc++;
        end
        i_start = 1'b0;
        check("t5_done_seen", 32'(o_done), 1);
        check("t5_accepts",   32'(acc), 4);
        check("t5_metric",    32'(o_best_metric), 9);
        check("t5_idx",       32'(o_best_idx), 2);
        i_cand_valid = 1'b1;
        i_cand       = t5[4];
        tick();
        check("t5_ready_idle", 32'(o_cand_ready), 0);
        check("t5_idle",       32'(o_busy), 0);
        check("t5_hold",       32'(o_best_metric), 9);
        i_cand_valid = 1'b0;

        // T6: reset after two accepts, then a clean 2-candidate batch
        start_batch(3);
        i_cand_valid = 1'b1;
        i_cand = mk(10'd20, 0, 0, 0, 0, 0, 0, 0);
        tick();
        i_cand = mk(10'd24, 0, 0, 0, 0, 0, 0, 0);
        tick();
        i_cand_valid = 1'b0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("t6_busy",   32'(o_busy), 0);
        check("t6_done",   32'(o_done), 0);
        check("t6_ready",  32'(o_cand_ready), 0);
        check("t6_metric", 32'(o_best_metric), 32'h3FF);
        check("t6_idx",    32'(o_best_idx), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_done === 1'b1) saw_done = 1'b1;
        end
        check("t6_no_done", 32'(saw_done), 0);
        start_batch(2);
        i_cand_valid = 1'b1;
        i_cand = mk(10'd80, 0, 0, 0, 0, 0, 0, 0);
        tick();
        i_cand = mk(0, 10'd28, 0, 0, 0, 0, 0, 0);
        tick();
        i_cand_valid = 1'b0;
        wait_done("t6b", 10);
        check("t6b_metric", 32'(o_best_metric), 7);
        check("t6b_idx",    32'(o_best_idx), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
